// File: rtl/logicnet_lut_pkg.sv
// Shared types and helpers for the runtime-programmable LogicNet LUT layer.
package logicnet_lut_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    CONFIG = 2'd3
  } lut_state_e;

  localparam lut_state_e LUT_RST_STATE = INIT;
  localparam logic       LUT_RST_FLAG  = 1'b0;

  function automatic int lut_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logicnet_lut_ram.sv
// One neuron truth table: synchronous write, asynchronous read, kept in LUT RAM.
module logicnet_lut_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/logicnet_lut_layer_rt.sv
// LogicNet layer of N_NEURONS writable truth tables with a registered valid/ready
// output, a post-reset clearing sweep and a drain-then-configure table port.
module logicnet_lut_layer_rt
  import logicnet_lut_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int IN_BITS   = 6,
  parameter int OUT_BITS  = 2,
  parameter int NW        = lut_idx_w(N_NEURONS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]  s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] m_data,
  input  logic                          cfg_req,
  output logic                          cfg_ack,
  input  logic                          cfg_we,
  input  logic                          cfg_re,
  input  logic [NW-1:0]                 cfg_neuron,
  input  logic [IN_BITS-1:0]            cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_wdata,
  output logic [OUT_BITS-1:0]           cfg_rdata,
  output logic                          cfg_rvalid
);

  localparam logic [IN_BITS:0] SWEEP_LAST = {1'b0, {IN_BITS{1'b1}}};
  localparam logic [IN_BITS:0] SWEEP_ONE  = {{IN_BITS{1'b0}}, 1'b1};

  lut_state_e                    state;
  logic [IN_BITS:0]              sweep_cnt;
  logic                          in_init;
  logic                          in_cfg;
  logic                          xfer;
  logic [31:0]                   cfg_idx;
  logic [IN_BITS-1:0]            tbl_waddr;
  logic [OUT_BITS-1:0]           tbl_wdata;
  logic [OUT_BITS-1:0]           tbl_rdata [N_NEURONS];
  logic [N_NEURONS*OUT_BITS-1:0] lookup_p0;
  logic [OUT_BITS-1:0]           rb_p0;
  logic                          vld_p1;
  logic [N_NEURONS*OUT_BITS-1:0] data_p1;

  assign in_init   = (state == INIT);
  assign in_cfg    = (state == CONFIG);
  assign s_ready   = (state == RUN) && (!vld_p1 || m_ready);
  assign xfer      = s_valid && s_ready;
  assign cfg_idx   = 32'(cfg_neuron);
  assign tbl_waddr = in_init ? sweep_cnt[IN_BITS-1:0] : cfg_addr;
  assign tbl_wdata = in_init ? '0 : cfg_wdata;

  // Tables share one address port: the config address in CONFIG, the datapath word otherwise.
  for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
    logic               we_k;
    logic [IN_BITS-1:0] raddr_k;

    assign we_k    = in_init || (in_cfg && cfg_we && (cfg_idx == 32'(k)));
    assign raddr_k = in_cfg ? cfg_addr : s_data[k*IN_BITS +: IN_BITS];

    logicnet_lut_ram #(
      .ADDR_W (IN_BITS),
      .DATA_W (OUT_BITS)
    ) u_ram (
      .clk   (clk),
      .we    (we_k),
      .waddr (tbl_waddr),
      .wdata (tbl_wdata),
      .raddr (raddr_k),
      .rdata (tbl_rdata[k])
    );

    assign lookup_p0[k*OUT_BITS +: OUT_BITS] = tbl_rdata[k];
  end

  // Out-of-range neuron indices match no table and read back as zero.
  always_comb begin
    rb_p0 = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (cfg_idx == 32'(k)) rb_p0 = tbl_rdata[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LUT_RST_STATE;
      sweep_cnt <= '0;
      cfg_ack   <= LUT_RST_FLAG;
    end else begin
      case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + SWEEP_ONE;
          if (sweep_cnt == SWEEP_LAST) state <= RUN;
        end
        RUN: begin
          if (cfg_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!cfg_req) begin
            state <= RUN;
          end else if (!vld_p1) begin
            state   <= CONFIG;
            cfg_ack <= 1'b1;
          end
        end
        CONFIG: begin
          if (!cfg_req) begin
            state   <= RUN;
            cfg_ack <= 1'b0;
          end
        end
        default: state <= LUT_RST_STATE;
      endcase
    end
  end

  // ---- stage p0 -> p1: parallel lookup result into the output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= LUT_RST_FLAG;
      data_p1 <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= lookup_p0;
    end else if (m_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign m_valid = vld_p1;
  assign m_data  = data_p1;

  // ---- stage p0 -> p1: table readback register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rvalid <= LUT_RST_FLAG;
      cfg_rdata  <= '0;
    end else begin
      cfg_rvalid <= in_cfg && cfg_re;
      if (in_cfg && cfg_re) cfg_rdata <= rb_p0;
    end
  end

endmodule

// File: tb/tb_logicnet_lut_layer_rt.sv
// Bench for logicnet_lut_layer_rt: directed config/drain/reset steps plus a
// randomized stream scored against a plain array model of the tables.
`timescale 1ns/1ps
module tb_logicnet_lut_layer_rt;

  // Five neurons make cfg_neuron 3 bits wide, so indices 5..7 are out of range.
  localparam int N     = 5;
  localparam int IB    = 6;
  localparam int OB    = 2;
  localparam int NWB   = 3;
  localparam int DEPTH = 64;
  localparam int SW    = N * IB;
  localparam int MW    = N * OB;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [SW-1:0]  s_data = '0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [MW-1:0]  m_data;
  logic           cfg_req = 1'b0;
  logic           cfg_ack;
  logic           cfg_we = 1'b0;
  logic           cfg_re = 1'b0;
  logic [NWB-1:0] cfg_neuron = '0;
  logic [IB-1:0]  cfg_addr = '0;
  logic [OB-1:0]  cfg_wdata = '0;
  logic [OB-1:0]  cfg_rdata;
  logic           cfg_rvalid;

  int checks = 0;
  int errors = 0;

  logic [OB-1:0] model [N][DEPTH];
  logic [MW-1:0] exp_q [$];

  logicnet_lut_layer_rt #(
    .N_NEURONS (N),
    .IN_BITS   (IB),
    .OUT_BITS  (OB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .cfg_req    (cfg_req),
    .cfg_ack    (cfg_ack),
    .cfg_we     (cfg_we),
    .cfg_re     (cfg_re),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .cfg_rvalid (cfg_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] ref_lookup(input logic [SW-1:0] d);
    logic [MW-1:0] r;
    logic [IB-1:0] a;
    r = '0;
    for (int k = 0; k < N; k++) begin
      a = d[k*IB +: IB];
      r[k*OB +: OB] = model[k][a];
    end
    return r;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < N; k++)
      for (int a = 0; a < DEPTH; a++)
        model[k][a] = '0;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!s_ready && n < 200) begin
      n++;
      tick();
    end
    chk(tag, n, DEPTH);
  endtask

  task automatic push(input logic [SW-1:0] d, input logic mr);
    s_data  = d;
    s_valid = 1'b1;
    m_ready = mr;
    #1;
    chk("push_ready", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic enter_cfg();
    int n;
    n = 0;
    cfg_req = 1'b1;
    while (!cfg_ack && n < 20) begin
      tick();
      n++;
    end
    chk("cfg_enter", cfg_ack, 1);
  endtask

  task automatic exit_cfg();
    cfg_req = 1'b0;
    tick();
    chk("cfg_exit_ack", cfg_ack, 0);
    chk("cfg_exit_ready", s_ready, 1);
  endtask

  task automatic cfg_wr(input int n, input int a, input logic [OB-1:0] d);
    cfg_neuron = NWB'(n);
    cfg_addr   = IB'(a);
    cfg_wdata  = d;
    cfg_we     = 1'b1;
    tick();
    cfg_we     = 1'b0;
    if (n < N) model[n][a] = d;
  endtask

  task automatic cfg_rd(input string tag, input int n, input int a, input logic [OB-1:0] exp);
    cfg_neuron = NWB'(n);
    cfg_addr   = IB'(a);
    cfg_re     = 1'b1;
    tick();
    cfg_re     = 1'b0;
    chk({tag, "_rvalid"}, cfg_rvalid, 1);
    chk(tag, cfg_rdata, exp);
  endtask

  logic [SW-1:0] d;
  logic [MW-1:0] held;
  logic [MW-1:0] expw;
  logic          hs_in;
  logic          hs_out;
  logic          stall;
  int            sent;
  int            got;
  int            bad;
  int            rn;
  int            ra;

  initial begin
    // Reset values while rst is held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_cfg_ack", cfg_ack, 0);
    chk("rst_cfg_rdata", cfg_rdata, 0);
    chk("rst_cfg_rvalid", cfg_rvalid, 0);
    rst = 1'b0;
    clear_model();
    wait_init("init_len");

    // Freshly swept tables return zero for any input
    push(SW'($urandom), 1'b0);
    chk("init_valid", m_valid, 1);
    chk("init_zero", m_data, 0);
    m_ready = 1'b1;
    tick();
    chk("drain_clear", m_valid, 0);

    // Directed table load and lookup
    enter_cfg();
    cfg_wr(0, 'h18, 2'b11);
    cfg_wr(2, 'h01, 2'b01);
    exit_cfg();
    d = '0;
    d[0*IB +: IB] = 6'h18;
    d[2*IB +: IB] = 6'h01;
    push(d, 1'b0);
    chk("plan_valid", m_valid, 1);
    chk("plan_word", m_data, 10'b00_00_01_00_11);

    // Config request stalls in DRAIN until the held word is consumed
    held    = m_data;
    cfg_req = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drain_ack_low", cfg_ack, 0);
      chk("drain_hold_valid", m_valid, 1);
      chk("drain_hold_data", m_data, held);
      chk("drain_s_ready", s_ready, 0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("drain_consumed", m_valid, 0);
    chk("ack_wait", cfg_ack, 0);
    tick();
    chk("ack_rise", cfg_ack, 1);

    // Readback, out-of-range neuron, write/read collision
    cfg_wr(3, 'h3F, 2'b10);
    cfg_rd("rb_n3", 3, 'h3F, 2'b10);
    tick();
    chk("rvalid_pulse", cfg_rvalid, 0);
    cfg_rd("rb_oob", 5, 'h3F, 2'b00);
    cfg_wr(5, 'h3F, 2'b01);
    cfg_wr(7, 'h18, 2'b00);
    for (int k = 0; k < N; k++) cfg_rd("rb_after_oob", k, 'h3F, model[k][6'h3F]);
    cfg_rd("rb_after_oob7", 0, 'h18, model[0][6'h18]);
    cfg_neuron = NWB'(1);
    cfg_addr   = IB'(7);
    cfg_wdata  = 2'b11;
    cfg_we     = 1'b1;
    cfg_re     = 1'b1;
    tick();
    cfg_we     = 1'b0;
    cfg_re     = 1'b0;
    chk("rw_old", cfg_rdata, model[1][7]);
    model[1][7] = 2'b11;
    cfg_rd("rw_new", 1, 7, 2'b11);

    // Random contents for every table
    for (int k = 0; k < N; k++)
      for (int a = 0; a < DEPTH; a++)
        cfg_wr(k, a, OB'($urandom_range(0, 3)));
    for (int i = 0; i < 10; i++) begin
      rn = $urandom_range(0, N - 1);
      ra = $urandom_range(0, DEPTH - 1);
      cfg_rd("rb_rand", rn, ra, model[rn][ra]);
    end
    exit_cfg();

    // Config strobes outside CONFIG are ignored
    cfg_neuron = '0;
    cfg_addr   = '0;
    cfg_wdata  = ~model[0][0];
    cfg_we     = 1'b1;
    cfg_re     = 1'b1;
    tick();
    cfg_we     = 1'b0;
    cfg_re     = 1'b0;
    chk("re_outside", cfg_rvalid, 0);
    push('0, 1'b1);
    chk("we_outside", m_data, ref_lookup('0));

    // Dropping cfg_req in DRAIN returns to RUN without ack
    m_ready = 1'b0;
    tick();
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    tick();
    chk("abort_ack", cfg_ack, 0);
    m_ready = 1'b1;
    #1;
    chk("abort_ready", s_ready, 1);
    tick();

    // Back-to-back words with m_ready held high
    for (int i = 0; i < 4; i++) begin
      s_data  = SW'($urandom);
      s_valid = 1'b1;
      m_ready = 1'b1;
      #1;
      chk("tput_ready", s_ready, 1);
      expw = ref_lookup(s_data);
      tick();
      chk("tput_valid", m_valid, 1);
      chk("tput_data", m_data, expw);
    end
    s_valid = 1'b0;
    tick();

    // Random stream with random backpressure against the table model
    sent = 0;
    got  = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 2000 && (sent < 100 || exp_q.size() > 0); cyc++) begin
      s_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
      s_data  = SW'($urandom);
      m_ready = ($urandom_range(0, 2) != 0);
      #1;
      hs_in  = s_valid && s_ready;
      hs_out = m_valid && m_ready;
      if (hs_out) begin
        chk("stream_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("stream_data", m_data, exp_q.pop_front());
          got++;
        end
      end
      if (hs_in) begin
        exp_q.push_back(ref_lookup(s_data));
        sent++;
      end
      stall = m_valid && !m_ready;
      held  = m_data;
      tick();
      if (stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_hold", m_data, held);
      end
    end
    s_valid = 1'b0;
    chk("stream_got", got, 100);
    chk("stream_q_empty", exp_q.size(), 0);
    chk("stream_idle", m_valid, 0);

    // Reset during RUN with a word held, then verify the sweep cleared everything
    push(SW'($urandom), 1'b0);
    chk("pre_rst_valid", m_valid, 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", m_valid, 0);
    chk("rst_mid_ready", s_ready, 0);
    rst = 1'b0;
    clear_model();
    wait_init("reinit_len");
    m_ready = 1'b1;
    enter_cfg();
    bad = 0;
    for (int k = 0; k < N; k++) begin
      for (int a = 0; a < DEPTH; a++) begin
        cfg_neuron = NWB'(k);
        cfg_addr   = IB'(a);
        cfg_re     = 1'b1;
        tick();
        if (cfg_rvalid !== 1'b1 || cfg_rdata !== 2'b00) bad++;
      end
    end
    cfg_re = 1'b0;
    chk("sweep_clear", bad, 0);
    exit_cfg();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
